// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 10010 sequence detectors, their stimulus
// generator (serial_pattern_tx) and the golden pattern model.
//   state_t      : transmitter FSM states
//   DEF_PATTERN  : default detected pattern, MSB is the oldest stream bit
//   DEF_PLEN     : default pattern length in bits
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [4:0] DEF_PATTERN = 5'b10010;
  localparam int         DEF_PLEN    = 5;

endpackage

// File: rtl/pattern_model.sv
// ---------------------------------------------------------------------------
// pattern_model
// Golden model of an overlapping Mealy pattern detector on a serial stream.
// A history register remembers the last PLEN-1 bits; hit compares that
// history plus the current bit against the pattern, so hit is aligned with
// the bit being presented. count is a saturating tally of hits.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (clears history and count)
//   bit_in : current stream bit (sampled every clock, idle fill included)
//   hit    : combinational match of {history, bit_in} against the pattern
//   count  : saturating number of clock edges at which hit was high
// ---------------------------------------------------------------------------
module pattern_model import seq_pkg::*; #(
  parameter int         PLEN    = DEF_PLEN,
  // Only the low PLEN bits are significant.
  parameter logic [7:0] PATTERN = 8'(DEF_PATTERN),
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  output logic             hit,
  output logic [CNT_W-1:0] count
);

  logic [PLEN-2:0]  hist_q;
  logic [PLEN-2:0]  hist_d;
  logic [PLEN-1:0]  window;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Oldest bit on the left, current bit on the right.
  assign window = {hist_q, bit_in};
  assign hit    = (window == PATTERN[PLEN-1:0]);
  assign hist_d = window[PLEN-2:0];
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (hit && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
// Accepts parallel words over a valid/ready handshake and serializes them
// MSB-first onto j, the input stream of the 10010 detectors. An embedded
// pattern_model produces exp_w, the expected Mealy detector output for the
// bit currently on j, plus a saturating count of expected detections.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   data_in   : word to transmit
//   load      : data_in valid
//   ready     : a word can be accepted this cycle
//   j         : serial bit to the detector (0 during idle fill)
//   j_valid   : j carries a data bit
//   exp_w     : expected Mealy detection for the current j
//   done      : high while the last bit of a word is on j
//   match_cnt : saturating count of exp_w assertions
// ---------------------------------------------------------------------------
module serial_pattern_tx import seq_pkg::*; #(
  parameter int         WIDTH   = 8,
  parameter logic [7:0] PATTERN = 8'(DEF_PATTERN),
  parameter int         PLEN    = DEF_PLEN,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             j,
  output logic             j_valid,
  output logic             exp_w,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            BW   = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [BW-1:0]    bitcnt_q;
  logic [BW-1:0]    bitcnt_d;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state_q == SHIFT) && (bitcnt_q == LAST);
  // The last-bit cycle can take the next word, giving gap-free streaming.
  assign ready    = !rst && ((state_q == IDLE) || last_bit);
  assign accept   = load && ready;

  // j is a pure function of registered state: the MSB of the shift
  // register while shifting, and forced 0 as idle fill.
  assign j        = (state_q == SHIFT) && shreg_q[WIDTH-1];
  assign j_valid  = (state_q == SHIFT);
  assign done     = last_bit;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (accept) begin
      state_d  = SHIFT;
      shreg_d  = data_in;
      bitcnt_d = '0;
    end else if (last_bit) begin
      state_d  = IDLE;
    end else if (state_q == SHIFT) begin
      shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
      bitcnt_d = bitcnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // The model sees every stream bit, idle zeros included, exactly as a
  // detector sampling j on each clock would.
  pattern_model #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_model (
    .clk    (clk),
    .rst    (rst),
    .bit_in (j),
    .hit    (exp_w),
    .count  (match_cnt)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_tx
// Directed, table-driven bench for serial_pattern_tx. Inputs are driven and
// outputs sampled on the falling clock edge. A second instance with
// CNT_W=2 exercises match counter saturation.
// ---------------------------------------------------------------------------
module tb_serial_pattern_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       load;
  logic       ready;
  logic       j;
  logic       j_valid;
  logic       exp_w;
  logic       done;
  logic [7:0] match_cnt;

  logic       rst2;
  logic [7:0] data2;
  logic       load2;
  logic       ready2;
  logic       j2;
  logic       j_valid2;
  logic       exp_w2;
  logic       done2;
  logic [1:0] match_cnt2;

  int n_vec = 0;
  int n_err = 0;

  serial_pattern_tx #(.WIDTH(8), .PLEN(5), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .load      (load),
    .ready     (ready),
    .j         (j),
    .j_valid   (j_valid),
    .exp_w     (exp_w),
    .done      (done),
    .match_cnt (match_cnt)
  );

  serial_pattern_tx #(.WIDTH(8), .PLEN(5), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst2),
    .data_in   (data2),
    .load      (load2),
    .ready     (ready2),
    .j         (j2),
    .j_valid   (j_valid2),
    .exp_w     (exp_w2),
    .done      (done2),
    .match_cnt (match_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One word sent from a freshly reset block, observed for 8 data cycles
  // plus 2 idle cycles. w_mask bit k is the expected exp_w in cycle k.
  typedef struct {
    logic [7:0] word;
    logic [9:0] w_mask;
    logic [7:0] cnt;
    bit         glitch;   // pulse load with 8'hFF during bits 2..3
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Leaves the bench at a falling edge with rst low and the block idle.
  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    step();
    check("rst_ready",   32'(ready),     32'd0);
    check("rst_j",       32'(j),         32'd0);
    check("rst_j_valid", 32'(j_valid),   32'd0);
    check("rst_done",    32'(done),      32'd0);
    check("rst_exp_w",   32'(exp_w),     32'd0);
    check("rst_cnt",     32'(match_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready",  32'(ready),     32'd1);
  endtask

  initial begin
    logic [15:0] stream;
    logic [16:0] b2b_mask;

    rst     = 1'b1;
    load    = 1'b0;
    data_in = '0;
    rst2    = 1'b1;
    load2   = 1'b0;
    data2   = '0;

    // Stream bits after the word are idle zeros, history before is zeros.
    // 10010010: windows end at bits 4 and 7 (overlapping).
    vecs[0] = '{word: 8'b10010010, w_mask: 10'b00_1001_0000, cnt: 8'd2, glitch: 1'b0};
    // 00001001: the first idle zero completes 1,0,0,1,0 (cycle 8).
    vecs[1] = '{word: 8'b00001001, w_mask: 10'b01_0000_0000, cnt: 8'd1, glitch: 1'b0};
    // all ones never match.
    vecs[2] = '{word: 8'hFF,       w_mask: 10'b00_0000_0000, cnt: 8'd0, glitch: 1'b0};
    // 10010000: single match at bit 4.
    vecs[3] = '{word: 8'b10010000, w_mask: 10'b00_0001_0000, cnt: 8'd1, glitch: 1'b0};
    // 01001001: match at bit 5 and at idle cycle 8.
    vecs[4] = '{word: 8'b01001001, w_mask: 10'b01_0010_0000, cnt: 8'd2, glitch: 1'b0};
    // Mid-word load pulse must be ignored: same result as vector 0.
    vecs[5] = '{word: 8'b10010010, w_mask: 10'b00_1001_0000, cnt: 8'd2, glitch: 1'b1};

    // ---------------- table-driven single words ----------------
    step();
    for (int v = 0; v < 6; v++) begin
      do_reset();
      load    = 1'b1;
      data_in = vecs[v].word;
      step();
      load = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (k < 8) begin
          check($sformatf("v%0d_j%0d", v, k),     32'(j),       32'(vecs[v].word[7-k]));
          check($sformatf("v%0d_jv%0d", v, k),    32'(j_valid), 32'd1);
          check($sformatf("v%0d_done%0d", v, k),  32'(done),    32'(k == 7));
          check($sformatf("v%0d_ready%0d", v, k), 32'(ready),   32'(k == 7));
        end else begin
          check($sformatf("v%0d_j%0d", v, k),     32'(j),       32'd0);
          check($sformatf("v%0d_jv%0d", v, k),    32'(j_valid), 32'd0);
          check($sformatf("v%0d_done%0d", v, k),  32'(done),    32'd0);
          check($sformatf("v%0d_ready%0d", v, k), 32'(ready),   32'd1);
        end
        check($sformatf("v%0d_expw%0d", v, k), 32'(exp_w), 32'(vecs[v].w_mask[k]));
        if (vecs[v].glitch && (k == 2 || k == 3)) begin
          load    = 1'b1;
          data_in = 8'hFF;
        end else begin
          load    = 1'b0;
        end
        step();
      end
      check($sformatf("v%0d_cnt", v), 32'(match_cnt), 32'(vecs[v].cnt));
      $display("vector %0d word=%b glitch=%0d match_cnt=%0d", v, vecs[v].word, vecs[v].glitch, match_cnt);
    end

    // ---------------- back-to-back words ----------------
    // Stream 1111_0010_0100_1111: 1,0,0,1,0 ends at index 7 (inside F2)
    // and at index 10 (spanning the word boundary). Trailing idle zeros
    // after ...1111 add none.
    stream   = 16'hF24F;
    b2b_mask = 17'b0_0000_0100_1000_0000;
    do_reset();
    load    = 1'b1;
    data_in = 8'hF2;
    step();
    data_in = 8'h4F;            // held high: ignored until the last-bit cycle
    for (int k = 0; k < 17; k++) begin
      if (k < 16) begin
        check($sformatf("b2b_j%0d", k),  32'(j),       32'(stream[15-k]));
        check($sformatf("b2b_jv%0d", k), 32'(j_valid), 32'd1);
      end else begin
        check("b2b_jv_end", 32'(j_valid), 32'd0);
        check("b2b_cnt",    32'(match_cnt), 32'd2);
      end
      check($sformatf("b2b_done%0d", k),  32'(done),  32'(k == 7 || k == 15));
      check($sformatf("b2b_ready%0d", k), 32'(ready), 32'(k == 7 || k >= 15));
      check($sformatf("b2b_expw%0d", k),  32'(exp_w), 32'(b2b_mask[k]));
      if (k == 8) load = 1'b0;
      step();
    end
    $display("back-to-back F2,4F match_cnt=%0d", match_cnt);

    // ---------------- reset mid-word, rst with load ----------------
    // History after bit 3 is 1,0,0,1: an unflushed history would flag a
    // match on the next zero.
    do_reset();
    load    = 1'b1;
    data_in = 8'b10010010;
    step();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mid_j%0d", k), 32'(j), 32'(k == 0 || k == 3));
      if (k < 3) step();
    end
    rst     = 1'b1;
    load    = 1'b1;             // dropped: reset takes priority
    data_in = 8'hFF;
    step();
    check("mid_rst_j",     32'(j),         32'd0);
    check("mid_rst_jv",    32'(j_valid),   32'd0);
    check("mid_rst_cnt",   32'(match_cnt), 32'd0);
    check("mid_rst_expw",  32'(exp_w),     32'd0);
    check("mid_rst_ready", 32'(ready),     32'd0);
    check("mid_rst_done",  32'(done),      32'd0);
    rst  = 1'b0;
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_jv%0d", i),   32'(j_valid),   32'd0);
      check($sformatf("post_rst_expw%0d", i), 32'(exp_w),     32'd0);
      check($sformatf("post_rst_cnt%0d", i),  32'(match_cnt), 32'd0);
    end
    $display("reset mid-word j_valid=%0d match_cnt=%0d", j_valid, match_cnt);

    // ---------------- saturation with CNT_W=2 ----------------
    // Three back-to-back 10010010 words: hits at stream indices
    // 4,7,12,15,20,23 -> 6 hits, count must stop at 3.
    rst2  = 1'b0;
    load2 = 1'b1;
    data2 = 8'b10010010;
    step();
    for (int k = 0; k < 30; k++) begin
      if (k == 8)  check("sat_cnt_k8",  32'(match_cnt2), 32'd2);
      if (k == 12) check("sat_cnt_k12", 32'(match_cnt2), 32'd2);
      if (k == 13) check("sat_cnt_k13", 32'(match_cnt2), 32'd3);
      if (k == 23) check("sat_expw_k23", 32'(exp_w2),    32'd1);
      if (k == 24) check("sat_cnt_k24", 32'(match_cnt2), 32'd3);
      if (k == 29) check("sat_cnt_k29", 32'(match_cnt2), 32'd3);
      if (k == 16) load2 = 1'b0;
      step();
    end
    $display("saturation CNT_W=2 match_cnt=%0d", match_cnt2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
